// File: rtl/rv32im_pkg.sv
// Shared RV32IM definitions: datapath width, EX-stage op codes, divider FSM states.
// Used by the ALU, decoder and divider so op-code encodings stay in one place.
package rv32im_pkg;

    localparam int unsigned RV_XLEN = 32;

    localparam logic [4:0] SEL_DIV  = 5'b01101;
    localparam logic [4:0] SEL_DIVU = 5'b01110;
    localparam logic [4:0] SEL_REM  = 5'b01111;
    localparam logic [4:0] SEL_REMU = 5'b10000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } div_state_t;

    function automatic logic is_div_sel(input logic [4:0] sel);
        return (sel == SEL_DIV) || (sel == SEL_DIVU) ||
               (sel == SEL_REM) || (sel == SEL_REMU);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the iterative divider.
interface div_unit_if
    import rv32im_pkg::*;
#(
    parameter int unsigned XLEN = RV_XLEN
);

    logic            START;
    logic [4:0]      SELECT;
    logic [XLEN-1:0] DATA1;
    logic [XLEN-1:0] DATA2;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;

    modport master (
        output START, SELECT, DATA1, DATA2,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, SELECT, DATA1, DATA2,
        output BUSY, DONE, RESULT
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not borrow.
module div_step
    import rv32im_pkg::*;
#(
    parameter int unsigned XLEN = RV_XLEN
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        trial   = shifted - {1'b0, divisor};
        // The extra top bit of the trial difference is the borrow.
        if (trial[XLEN]) begin
            rem_out = shifted[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end else begin
            rem_out = trial[XLEN-1:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Fixed-latency iterative divider for DIV/DIVU/REM/REMU: one restoring step
// per cycle on operand magnitudes, sign fix-up and special cases at the end.
module div_unit
    import rv32im_pkg::*;
#(
    parameter int unsigned XLEN = RV_XLEN
) (
    input  logic       CLK,
    input  logic       RESET,
    div_unit_if.slave  bus
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t state;
    div_state_t state_nxt;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvsr_q;
    logic [XLEN-1:0] dividend_q;
    logic            is_rem_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            dz_q;
    logic            ovf_q;
    logic [XLEN-1:0] result_q;
    logic            done_q;

    logic            accept;
    logic            signed_op;
    logic            rem_op;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] step_quo;
    logic [XLEN-1:0] fin_result;

    always_comb begin
        accept    = (state == IDLE) && bus.START && is_div_sel(bus.SELECT);
        signed_op = (bus.SELECT == SEL_DIV) || (bus.SELECT == SEL_REM);
        rem_op    = (bus.SELECT == SEL_REM) || (bus.SELECT == SEL_REMU);
        mag_a     = (signed_op && bus.DATA1[XLEN-1]) ? -bus.DATA1 : bus.DATA1;
        mag_b     = (signed_op && bus.DATA2[XLEN-1]) ? -bus.DATA2 : bus.DATA2;
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (cnt == CW'(XLEN - 1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Special cases still run the full iteration so latency never varies.
    always_comb begin
        fin_result = '0;
        if (dz_q)
            fin_result = is_rem_q ? dividend_q : '1;
        else if (ovf_q)
            fin_result = is_rem_q ? '0 : MIN_NEG;
        else if (is_rem_q)
            fin_result = neg_rem_q ? -rem_q : rem_q;
        else
            fin_result = neg_quo_q ? -quo_q : quo_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            dividend_q <= '0;
            is_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt        <= '0;
                        rem_q      <= '0;
                        quo_q      <= mag_a;
                        dvsr_q     <= mag_b;
                        dividend_q <= bus.DATA1;
                        is_rem_q   <= rem_op;
                        neg_quo_q  <= (bus.SELECT == SEL_DIV) &&
                                      (bus.DATA1[XLEN-1] ^ bus.DATA2[XLEN-1]);
                        neg_rem_q  <= (bus.SELECT == SEL_REM) && bus.DATA1[XLEN-1];
                        dz_q       <= (bus.DATA2 == '0);
                        ovf_q      <= signed_op && (bus.DATA1 == MIN_NEG) &&
                                      (bus.DATA2 == '1);
                    end
                end
                CALC: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt   <= cnt + 1'b1;
                end
                FIN: begin
                    result_q <= fin_result;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.BUSY   = (state != IDLE);
    assign bus.DONE   = done_q;
    assign bus.RESULT = result_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port START  input  1  request; sampled only when BUSY=0.
REQ-005 SHALL have port SELECT  input  5  op code: 01101 DIV, 01110 DIVU, 01111 REM, 10000 REMU (same encoding as EX-stage ALU).
REQ-006 SHALL have port DATA1  input  32  dividend (rs1 value).
REQ-007 SHALL have port DATA2  input  32  divisor (rs2 value).
REQ-008 SHALL have port BUSY  output  1  high while an operation is in flight; drives EX-stage stall.
REQ-009 SHALL have port DONE  output  1  one-cycle pulse; RESULT valid in that cycle.
REQ-010 SHALL have port RESULT  output  32  quotient or remainder, registered, held until next DONE.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIN; BUSY = (state != IDLE).
REQ-012 SHALL accept START at edge e0 only if state=IDLE and SELECT is one of the four codes; any other SELECT with START is ignored (no state change, no DONE).
REQ-013 SHALL, on accept, latch op, operand magnitudes, quotient sign (DIV only: sign(DATA1)^sign(DATA2)), remainder sign (REM only: sign(DATA1)), special-case flags; zero iteration counter; go CALC.
REQ-014 SHALL perform one radix-2 restoring step per CALC cycle, 32 steps, counter 0..31; go FIN after step 31.
REQ-015 SHALL, at the FIN edge, apply sign correction (two's complement negate), write RESULT, pulse DONE, return to IDLE.
REQ-016 SHALL have fixed latency: START accepted at e0 -> DONE=1 and RESULT valid after edge e0+33, for exactly one cycle, for all operands incl. special cases.
REQ-017 SHALL treat DIVU/REMU operands as unsigned 32-bit, DIV/REM as two's complement; quotient truncates toward zero; remainder sign follows dividend.
REQ-018 SHALL return on divisor zero: DIV/DIVU 0xFFFFFFFF; REM/REMU DATA1 unchanged.
REQ-019 SHALL return on signed overflow (DIV/REM, DATA1=0x80000000, DATA2=0xFFFFFFFF): DIV 0x80000000, REM 0.
REQ-020 SHALL ignore START while BUSY=1; latched operands unaffected by DATA1/DATA2/SELECT changes during CALC/FIN.
REQ-021 SHALL accept a new START in the DONE cycle (state already IDLE), giving back-to-back ops with one idle gap of zero cycles.
REQ-022 SHALL keep RESULT unchanged between DONE pulses.

Reset
REQ-023 SHALL, when RESET=1 at an edge, force state IDLE, counter 0, BUSY 0, DONE 0, RESULT 0, regardless of state; RESET has priority over START.
REQ-024 SHALL abort an in-flight op on mid-operation RESET with no DONE pulse for it.

Structure
REQ-025 SHALL take SELECT op codes, XLEN and FSM state encoding from shared package rv32im_pkg, also used by the ALU and decoder.
REQ-026 SHALL isolate one restoring step (shift, trial subtract, quotient bit) in sub-module div_step; no other sub-modules.
REQ-027 SHALL contain no combinational path from inputs to BUSY, DONE or RESULT.

Verification
REQ-028 SHALL test DIVU 100/7: START at e0 -> RESULT 14 at e0+33, DONE high one cycle; REMU same -> 2.
REQ-029 SHALL test signed: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-030 SHALL test divide by zero: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0xFFFFFFFB/0 -> 0xFFFFFFFF; latency still 33.
REQ-031 SHALL test overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-032 SHALL test START with new operands at e0+5 (ignored, first result correct); RESET at e0+10 -> BUSY 0 next cycle, no DONE, RESULT 0.
REQ-033 SHALL test back-to-back: second START in first DONE cycle -> second DONE exactly 33 edges later; SELECT 00001 with START -> BUSY stays 0.
